// File: rtl/hilo_divider_unit.sv
// hilo_divider_unit
//   Owns the architectural HI/LO registers that sit downstream of the ALU.
//   It captures single-cycle mult/multu products and serves mthi/mtlo writes
//   and mfhi/mflo reads. It also runs div/divu as a restoring divider that
//   takes one quotient bit per cycle, and stalls decode through busy while a
//   divide is running.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   mult_valid  ALU product valid; datahi/datalo go to HI/LO
//   datahi      ALU product upper word
//   datalo      ALU product lower word
//   div_start   start a divide; div_signed selects div (1) or divu (0)
//   div_signed  signedness of the divide, sampled with div_start
//   rs_data     dividend, or source for mthi/mtlo
//   rt_data     divisor
//   mthi/mtlo   write rs_data to HI/LO
//   mfhi/mflo   read request; held by decode until rd_valid
//   busy        divide in progress
//   rd_valid    rd_data carries a read result (one pulse per request cycle)
//   rd_data     registered read result; holds its last value
//   hi/lo       current HI/LO
//
// Configuration: DIV_CYCLES must equal WIDTH. The divider produces one
// quotient bit per step.
module hilo_divider_unit #(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mult_valid,
    input  logic [WIDTH-1:0] datahi,
    input  logic [WIDTH-1:0] datalo,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             mfhi,
    input  logic             mflo,
    output logic             busy,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's-complement negate.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    // Magnitude of an operand: negated only when signed and negative.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = negate(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] rem_r;      // partial remainder
    logic [WIDTH-1:0] dvd_r;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_r;      // divisor magnitude
    logic [CNT_W-1:0] cnt_r;
    logic             signed_r;
    logic             neg_q_r;    // operand signs differ
    logic             neg_r_r;    // dividend negative
    logic             dz_r;       // divisor was zero
    logic             busy_r;
    logic             rd_valid_r;
    logic [WIDTH-1:0] rd_data_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   rem_diff_s;
    logic             take_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] fix_lo_s;
    logic [WIDTH-1:0] fix_hi_s;

    // One restoring step. The shifted remainder needs WIDTH+1 bits because a
    // divisor above 2^(WIDTH-1) can let it exceed WIDTH bits. A clear borrow
    // bit means rem >= divisor.
    always_comb begin
        rem_shift_s = {rem_r, dvd_r[WIDTH-1]};
        rem_diff_s  = rem_shift_s - {1'b0, dvs_r};
        take_s      = ~rem_diff_s[WIDTH];
        if (take_s) begin
            rem_next_s = rem_diff_s[WIDTH-1:0];
        end else begin
            rem_next_s = rem_shift_s[WIDTH-1:0];
        end
    end

    // Sign fixup of the final quotient and remainder.
    // Divide by zero: every step subtracts 0, so the quotient is all ones and
    // the remainder accumulates |rs|. Restoring the sign of rs on that
    // remainder gives back the original rs_data, so only the quotient
    // negation has to be suppressed.
    always_comb begin
        fix_lo_s = dvd_r;
        fix_hi_s = rem_r;
        if (dz_r) begin
            fix_lo_s = ALL_ONES;
        end else if (signed_r && neg_q_r) begin
            fix_lo_s = negate(dvd_r);
        end else begin
            fix_lo_s = dvd_r;
        end
        if (signed_r && neg_r_r) begin
            fix_hi_s = negate(rem_r);
        end else begin
            fix_hi_s = rem_r;
        end
    end

    // Control FSM, divider datapath, HI/LO state and the read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rem_r      <= ALL_ZERO;
            dvd_r      <= ALL_ZERO;
            dvs_r      <= ALL_ZERO;
            cnt_r      <= CNT_ZERO;
            signed_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            dz_r       <= 1'b0;
            busy_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= ALL_ZERO;
            hi_r       <= ALL_ZERO;
            lo_r       <= ALL_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Reads see pre-write HI/LO because the writes below are
                    // non-blocking.
                    if (mfhi || mflo) begin
                        rd_valid_r <= 1'b1;
                        rd_data_r  <= mfhi ? hi_r : lo_r;
                    end else begin
                        rd_valid_r <= 1'b0;
                    end

                    if (div_start) begin
                        signed_r <= div_signed;
                        neg_q_r  <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
                        neg_r_r  <= rs_data[WIDTH-1];
                        dz_r     <= (rt_data == ALL_ZERO);
                        dvd_r    <= magnitude(rs_data, div_signed);
                        dvs_r    <= magnitude(rt_data, div_signed);
                        rem_r    <= ALL_ZERO;
                        cnt_r    <= CNT_LAST;
                        busy_r   <= 1'b1;
                        state_r  <= ST_DIV;
                    end else if (mult_valid) begin
                        hi_r <= datahi;
                        lo_r <= datalo;
                    end else begin
                        if (mthi) begin
                            hi_r <= rs_data;
                        end else begin
                            hi_r <= hi_r;
                        end
                        if (mtlo) begin
                            lo_r <= rs_data;
                        end else begin
                            lo_r <= lo_r;
                        end
                    end
                end

                ST_DIV: begin
                    rd_valid_r <= 1'b0;
                    rem_r      <= rem_next_s;
                    dvd_r      <= {dvd_r[WIDTH-2:0], take_s};
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end

                ST_FIX: begin
                    rd_valid_r <= 1'b0;
                    lo_r       <= fix_lo_s;
                    hi_r       <= fix_hi_s;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end

                default: begin
                    rd_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_hilo_divider_unit.sv
// Testbench for hilo_divider_unit. Directed vectors with hand-computed
// results. Each read request pushes its expected rd_data onto a scoreboard
// queue, and a monitor pops and compares on every rd_valid.
module tb_hilo_divider_unit;

    logic        clk;
    logic        rst_n;
    logic        mult_valid;
    logic [31:0] datahi;
    logic [31:0] datalo;
    logic        div_start;
    logic        div_signed;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        mfhi;
    logic        mflo;
    logic        busy;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    string       name_q[$];

    hilo_divider_unit #(.WIDTH(32), .DIV_CYCLES(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mult_valid (mult_valid),
        .datahi     (datahi),
        .datalo     (datalo),
        .div_start  (div_start),
        .div_signed (div_signed),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .mfhi       (mfhi),
        .mflo       (mflo),
        .busy       (busy),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .hi         (hi),
        .lo         (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every rd_valid against the queue head.
    task automatic monitor();
        logic [31:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (busy) begin
                check("rd_valid_while_busy", {31'b0, rd_valid}, 32'd0);
            end
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd_valid: rd_data=0x%08h with no read pending", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check(n, rd_data, e);
                end
            end
        end
    endtask

    // One-cycle read request, issued at a negedge.
    task automatic read_reg(input logic is_hi, input logic [31:0] exp, input string name);
        mfhi = is_hi;
        mflo = ~is_hi;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        mfhi = 1'b0;
        mflo = 1'b0;
    endtask

    // Issue a divide, count busy cycles, and optionally inject the requests
    // that must be dropped while busy, or hold an mfhi through the divide.
    task automatic do_div(input logic sgn, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic junk, input logic hold_rd, input string tag);
        int n;
        div_start  = 1'b1;
        div_signed = sgn;
        rs_data    = rs;
        rt_data    = rt;
        @(negedge clk);
        div_start = 1'b0;
        rs_data   = 32'd0;
        rt_data   = 32'd0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (hold_rd && n == 1) begin
                mfhi = 1'b1;
                exp_q.push_back(exp_hi);
                name_q.push_back({tag, "_held_mfhi"});
            end
            if (junk && n == 5) begin
                mult_valid = 1'b1;
                datahi     = 32'hAAAA5555;
                datalo     = 32'h5555AAAA;
                mthi       = 1'b1;
                mtlo       = 1'b1;
                div_start  = 1'b1;
                rs_data    = 32'h00000009;
                rt_data    = 32'h00000001;
            end else begin
                mult_valid = 1'b0;
                mthi       = 1'b0;
                mtlo       = 1'b0;
                div_start  = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, n, 32'd33);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
        if (hold_rd) begin
            @(negedge clk);
            check({tag, "_held_rd_valid_timing"}, {31'b0, rd_valid}, 32'd1);
            mfhi = 1'b0;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        mult_valid = 1'b0;
        datahi     = 32'd0;
        datalo     = 32'd0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        rs_data    = 32'd0;
        rt_data    = 32'd0;
        mthi       = 1'b0;
        mtlo       = 1'b0;
        mfhi       = 1'b0;
        mflo       = 1'b0;
        fork
            monitor();
        join_none

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0, 1'b0, "divu_100_7");
        read_reg(1'b1, 32'h00000002, "divu_100_7_mfhi");
        read_reg(1'b0, 32'h0000000E, "divu_100_7_mflo");

        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1, 1'b0, "div_m7_2_busy_drop");
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, "div_overflow");
        do_div(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h00000005, 1'b0, 1'b0, "divu_by_zero");
        do_div(1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b0, "div_by_zero_neg");

        // mthi and mtlo in the same cycle, then mtlo alone.
        rs_data = 32'hDEADBEEF;
        mthi    = 1'b1;
        mtlo    = 1'b1;
        @(negedge clk);
        mthi    = 1'b0;
        rs_data = 32'h0BADF00D;
        @(negedge clk);
        mtlo    = 1'b0;
        check("mthi_mtlo_hi", hi, 32'hDEADBEEF);
        check("mtlo_only_lo", lo, 32'h0BADF00D);

        // A read in the same cycle as a write returns the pre-write value.
        rs_data = 32'h11111111;
        mthi    = 1'b1;
        mfhi    = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        name_q.push_back("read_during_write");
        @(negedge clk);
        mthi = 1'b0;
        mfhi = 1'b0;
        @(negedge clk);
        check("write_after_read_hi", hi, 32'h11111111);

        // mfhi held through a divide returns the post-divide HI.
        do_div(1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0, 1'b1, "divu_held_read");
        @(negedge clk);

        // mult_valid takes priority over mthi.
        rs_data    = 32'h00000001;
        mthi       = 1'b1;
        mult_valid = 1'b1;
        datahi     = 32'h12345678;
        datalo     = 32'h9ABCDEF0;
        @(negedge clk);
        mthi       = 1'b0;
        mult_valid = 1'b0;
        check("mult_over_mthi_hi", hi, 32'h12345678);
        check("mult_lo", lo, 32'h9ABCDEF0);
        read_reg(1'b1, 32'h12345678, "mult_mfhi");
        read_reg(1'b0, 32'h9ABCDEF0, "mult_mflo");
        @(negedge clk);

        // Reset in the middle of a divide discards it.
        div_start  = 1'b1;
        div_signed = 1'b0;
        rs_data    = 32'd100;
        rt_data    = 32'd7;
        @(negedge clk);
        div_start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_div_busy_before_reset", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_div_reset_busy", {31'b0, busy}, 32'd0);
        check("mid_div_reset_hi", hi, 32'd0);
        check("mid_div_reset_lo", lo, 32'd0);
        repeat (40) @(negedge clk);
        check("mid_div_never_completes_hi", hi, 32'd0);
        check("mid_div_never_completes_lo", lo, 32'd0);
        check("mid_div_stays_idle", {31'b0, busy}, 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_divider_unit.md
Name: hilo_divider_unit

Overview:
- Downstream of the ALU. Owns the architectural HI/LO registers.
- Captures the ALU's single-cycle mult/multu results (datahi/datalo).
- Executes div/divu iteratively over multiple cycles, replacing the combinational divide path.
- Serves mthi/mtlo writes and mfhi/mflo reads, with a busy stall towards decode.

Parameters:
- WIDTH, 32, data width of HI, LO and operands.
- DIV_CYCLES, 32, iteration count of the restoring divider; must equal WIDTH.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- mult_valid  in  1  ALU mult/multu result valid this cycle.
- datahi  in  32  ALU product upper word.
- datalo  in  32  ALU product lower word.
- div_start  in  1  start div/divu.
- div_signed  in  1  1 = div, 0 = divu; sampled with div_start.
- rs_data  in  32  dividend, or mthi/mtlo source.
- rt_data  in  32  divisor.
- mthi  in  1  write rs_data to HI.
- mtlo  in  1  write rs_data to LO.
- mfhi  in  1  read HI; held high by decode until rd_valid.
- mflo  in  1  read LO; held high by decode until rd_valid.
- busy  out  1  divide in progress; decode stalls.
- rd_valid  out  1  rd_data holds a read result.
- rd_data  out  32  registered mfhi/mflo result.
- hi  out  32  current HI.
- lo  out  32  current LO.

Behaviour:
- Reset (rst_n low at an edge): hi=0, lo=0, busy=0, rd_valid=0, rd_data=0, FSM to IDLE. An in-flight divide is discarded. Reset mid-divide leaves HI/LO at 0, not partial results.
- States: IDLE, DIV, FIX. busy = (state != IDLE).
- IDLE + div_start:
  - Latch sign flags.
  - Latch |rs| and |rt| when signed (two's-complement negate if bit31 set); raw values when unsigned.
  - Clear remainder; load iteration counter = DIV_CYCLES-1; go to DIV.
- DIV: one restoring step per cycle.
  - rem = {rem[30:0], dvd[31]}; dvd <<= 1.
  - If rem >= divisor: rem -= divisor and dvd[0] = 1.
  - After the counter = 0 step, go to FIX.
- FIX (1 cycle):
  - Signed: negate quotient if sign(rs) != sign(rt); remainder takes the sign of rs.
  - Write lo = quotient, hi = remainder at the closing edge; go to IDLE.
- Latency: div_start accepted at edge E0; busy high for cycles E0+1..E0+33; hi/lo new at edge E0+33; busy low from the following cycle.
- Divide by zero (either mode): completes with the same latency; lo = 0xFFFFFFFF, hi = original rs_data; no sign fixup.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives lo = 0x80000000, hi = 0.
- While busy: div_start, mult_valid, mthi and mtlo are ignored (decode guarantees stall; the bench checks they are dropped).
- IDLE writes, by priority:
  - mult_valid: hi=datahi, lo=datalo; overrides mthi/mtlo.
  - Otherwise mthi writes hi and mtlo writes lo; both may fire in the same cycle.
  - div_start together with mult_valid/mthi/mtlo: div_start wins; the others are dropped.
- Reads:
  - In IDLE with mfhi or mflo high: rd_data = hi (mfhi priority) or lo, registered, so rd_valid is high the next cycle.
  - rd_valid is a 1-cycle pulse per request cycle.
  - A write in the same cycle as a read: the read returns the pre-write value.
  - A read while busy: rd_valid stays 0. The held request is serviced in the first IDLE cycle and returns the post-divide value.
- rd_valid deasserts the cycle after the request drops. rd_data holds its last value.

Test Plan:
- Reset: rst_n low 2 cycles -> hi=0, lo=0, busy=0, rd_valid=0.
- divu rs=100, rt=7 -> busy high exactly 33 cycles; then lo=14 (0x0000000E), hi=2.
- div signed rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu rs=5, rt=0 -> lo=0xFFFFFFFF, hi=5 after 33 busy cycles.
- mfhi held during a divide with expected hi=2 -> rd_valid stays 0 while busy; rd_valid=1 with rd_data=2 the cycle after busy falls.
- IDLE, mult_valid with datahi=0x12345678, datalo=0x9ABCDEF0, plus mthi with rs=1 -> hi=0x12345678, lo=0x9ABCDEF0.
- Mid-divide: assert rst_n low at cycle 10 of DIV -> busy=0, hi=lo=0 next cycle; the divide never completes.
